// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT: register offsets within the 64 KiB window,
// the bus handshake state type and a byte-lane merge helper.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// CLINT timer: optional prescaler (CLINT_PRESCALER_EN), 64-bit mtime with a
// half-word write port, and the registered mtime >= mtimecmp compare.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned rtc_div = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [63:0] mtimecmp,
    output logic [63:0] mtime,
    output logic        mtip
);

    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic        mtip_q, mtip_d;

`ifdef CLINT_PRESCALER_EN
    logic [15:0] presc_q, presc_d;

    always_comb begin
        tick    = (presc_q == 16'(rtc_div - 1));
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= 16'd0;
        else     presc_q <= presc_d;
    end
`else
    logic unused_div;
    assign unused_div = (rtc_div == 0);
    assign tick       = 1'b1;
`endif

    // A bus write to either half wins over the increment for that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_lo)      mtime_d[31:0]  = merge_bytes(mtime_q[31:0], wdata, wstrb);
        else if (wr_hi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata, wstrb);
        else if (tick)  mtime_d = mtime_q + 64'd1;
        mtip_d = (mtime_q >= mtimecmp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q <= 64'd0;
            mtip_q  <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            mtip_q  <= mtip_d;
        end
    end

    assign mtime = mtime_q;
    assign mtip  = mtip_q;

endmodule

// File: rtl/clint.sv
// CLINT top: two-state bus handshake, address decode, msip and mtimecmp.
// Macro CLINT_PRESCALER_EN enables the rtc_div prescaler inside clint_timer.
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] clint_base = 32'h0200_0000,
    parameter int unsigned rtc_div    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime
);

    state_e      state_q, state_d;
    logic [15:0] off_q, off_d;
    logic        win_q, win_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    logic [31:0] offset;
    logic [15:0] word_off;
    logic        in_win;
    logic [31:0] rd_val;
    logic        wr_en, wr_mtime_lo, wr_mtime_hi;
    logic        unused_instr;

    assign unused_instr = mem_instr;

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        offset   = mem_addr - clint_base;
        in_win   = (offset[31:16] == 16'd0);
        word_off = {offset[15:2], 2'b00};
        rd_val   = 32'd0;
        if (in_win) begin
            case (word_off)
                CLINT_MSIP:        rd_val = {31'd0, msip_q};
                CLINT_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
                CLINT_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
                CLINT_MTIME_LO:    rd_val = mtime[31:0];
                CLINT_MTIME_HI:    rd_val = mtime[63:32];
                default:           rd_val = 32'd0;
            endcase
        end
    end

    // Writes commit from the captured request at the edge that ends RESP.
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        win_d      = win_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    state_d = RESP;
                    off_d   = word_off;
                    win_d   = in_win;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    rdata_d = rd_val;
                end
            end
            RESP: begin
                state_d = IDLE;
                wr_en   = win_q && (wstrb_q != 4'b0000);
                if (wr_en) begin
                    case (off_q)
                        CLINT_MSIP:        if (wstrb_q[0]) msip_d = wdata_q[0];
                        CLINT_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_q, wstrb_q);
                        CLINT_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_q, wstrb_q);
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        wr_mtime_lo = wr_en && (off_q == CLINT_MTIME_LO);
        wr_mtime_hi = wr_en && (off_q == CLINT_MTIME_HI);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            off_q      <= 16'd0;
            win_q      <= 1'b0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            rdata_q    <= 32'd0;
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            win_q      <= win_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    clint_timer #(
        .rtc_div (rtc_div)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .wr_lo    (wr_mtime_lo),
        .wr_hi    (wr_mtime_hi),
        .wdata    (wdata_q),
        .wstrb    (wstrb_q),
        .mtimecmp (mtimecmp_q),
        .mtime    (mtime),
        .mtip     (mtip)
    );

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = (state_q == RESP) ? rdata_q : 32'd0;
    assign msip      = msip_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: bus handshake, decode, msip, mtip, mtime carry,
// reset during RESP, and the rtc_div=4 prescaler (CLINT_PRESCALER_EN).
module tb_clint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic [31:0] mem_rdata;
    logic        mem_ready, msip, mtip;
    logic [63:0] mtime;

    logic [31:0] rdata4;
    logic        ready4, msip4, mtip4;
    logic [63:0] mtime4;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      ecnt;
    longint      ecnt_base = 0;
    logic [63:0] mt_base = 64'd0;
    logic [63:0] exp4_tbl [0:7];

    always #5 clk = ~clk;

    clint dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .msip      (msip),
        .mtip      (mtip),
        .mtime     (mtime)
    );

    clint #(.rtc_div(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (1'b0),
        .mem_instr (1'b0),
        .mem_addr  (32'd0),
        .mem_wdata (32'd0),
        .mem_wstrb (4'd0),
        .mem_rdata (rdata4),
        .mem_ready (ready4),
        .msip      (msip4),
        .mtip      (mtip4),
        .mtime     (mtime4)
    );

    // Rising edges seen since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    function automatic logic [63:0] exp_mtime();
        return mt_base + 64'(ecnt - ecnt_base);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge; returns at the falling edge after the commit edge.
    task automatic bus(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        #1 check({tag, " ready_pre"}, 64'(mem_ready), 64'd0);
        @(negedge clk);
        check({tag, " ready"}, 64'(mem_ready), 64'd1);
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        @(negedge clk);
        check({tag, " ready_end"}, 64'(mem_ready), 64'd0);
        check({tag, " rdata_idle"}, 64'(mem_rdata), 64'd0);
    endtask

    task automatic mt_write(input string tag, input logic hi, input logic [31:0] d,
                            input logic [3:0] s);
        logic [63:0] r;
        logic [31:0] rd;
        r = exp_mtime() + 64'd1;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                if (hi) r[32 + 8*i +: 8] = d[8*i +: 8];
                else    r[8*i +: 8]      = d[8*i +: 8];
            end
        end
        bus(tag, hi ? 32'h0200_BFFC : 32'h0200_BFF8, d, s, rd);
        mt_base   = r;
        ecnt_base = ecnt;
        check({tag, " mtime"}, mtime, r);
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] e0;
        bit          reached;

`ifdef CLINT_PRESCALER_EN
        exp4_tbl = '{64'd0, 64'd0, 64'd0, 64'd1, 64'd1, 64'd1, 64'd1, 64'd2};
`else
        exp4_tbl = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
`endif

        repeat (2) @(negedge clk);
        check("rst ready", 64'(mem_ready), 64'd0);
        check("rst rdata", 64'(mem_rdata), 64'd0);
        check("rst msip", 64'(msip), 64'd0);
        check("rst mtip", 64'(mtip), 64'd0);
        check("rst mtime", mtime, 64'd0);
        check("rst mtime4", mtime4, 64'd0);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check("mtime run", mtime, 64'd3);

        e0 = exp_mtime();
        bus("rd mtime_lo", 32'h0200_BFF8, 32'd0, 4'd0, rd);
        check("rd mtime_lo val", 64'(rd), 64'(e0[31:0]));
        check("idle mtip", 64'(mtip), 64'd0);
        check("idle msip", 64'(msip), 64'd0);
        bus("rd mtime_hi", 32'h0200_BFFC, 32'd0, 4'd0, rd);
        check("rd mtime_hi val", 64'(rd), 64'd0);
        bus("rd cmp_lo", 32'h0200_4000, 32'd0, 4'd0, rd);
        check("rd cmp_lo rst", 64'(rd), 64'hFFFF_FFFF);
        bus("rd cmp_hi", 32'h0200_4004, 32'd0, 4'd0, rd);
        check("rd cmp_hi rst", 64'(rd), 64'hFFFF_FFFF);

        bus("wr msip1", 32'h0200_0000, 32'h0000_0001, 4'b0001, rd);
        check("msip set", 64'(msip), 64'd1);
        bus("rd msip", 32'h0200_0000, 32'd0, 4'd0, rd);
        check("rd msip val", 64'(rd), 64'd1);
        bus("wr msip nolane", 32'h0200_0000, 32'h0000_0000, 4'b1110, rd);
        check("msip lane0 only", 64'(msip), 64'd1);
        bus("wr msip0", 32'h0200_0000, 32'hFFFF_FFFE, 4'b0001, rd);
        check("msip clear", 64'(msip), 64'd0);

        bus("wr outside", 32'h0300_0000, 32'h0000_0001, 4'b0001, rd);
        check("outside no write", 64'(msip), 64'd0);
        bus("rd outside", 32'h0300_0000, 32'd0, 4'd0, rd);
        check("rd outside val", 64'(rd), 64'd0);
        bus("rd below", 32'h01FF_FFFC, 32'd0, 4'd0, rd);
        check("rd below val", 64'(rd), 64'd0);
        bus("rd unmapped", 32'h0200_0008, 32'd0, 4'd0, rd);
        check("rd unmapped val", 64'(rd), 64'd0);
        e0 = exp_mtime();
        bus("rd unaligned", 32'h0200_BFFB, 32'd0, 4'd0, rd);
        check("rd unaligned val", 64'(rd), 64'(e0[31:0]));

        mt_write("wr mtime50", 1'b0, 32'd50, 4'b1111);
        bus("wr cmp_hi", 32'h0200_4004, 32'd0, 4'b1111, rd);
        bus("wr cmp_lo", 32'h0200_4000, 32'd100, 4'b1111, rd);
        bus("rd cmp_lo", 32'h0200_4000, 32'd0, 4'd0, rd);
        check("rd cmp_lo 100", 64'(rd), 64'd100);
        check("mtip below", 64'(mtip), 64'd0);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_mtime() == 64'd100) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mtime reach 100", 64'(reached), 64'd1);
        check("mtime at 100", mtime, 64'd100);
        check("mtip lag", 64'(mtip), 64'd0);
        @(negedge clk);
        check("mtip rise", 64'(mtip), 64'd1);
        repeat (5) @(negedge clk);
        check("mtip hold", 64'(mtip), 64'd1);
        bus("wr cmp_lo ones", 32'h0200_4000, 32'hFFFF_FFFF, 4'b1111, rd);
        bus("wr cmp_hi ones", 32'h0200_4004, 32'hFFFF_FFFF, 4'b1111, rd);
        @(negedge clk);
        check("mtip drop", 64'(mtip), 64'd0);

        mt_write("wr mtime lo ones", 1'b0, 32'hFFFF_FFFF, 4'b1111);
        check("carry before", mtime, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check("carry after", mtime, 64'h0000_0001_0000_0000);
        mt_write("wr mtime hi byte1", 1'b1, 32'h0000_AB00, 4'b0010);
        check("hi byte1 merge", 64'(mtime[63:32]), 64'h0000_AB01);
        @(negedge clk);
        check("mtime after hi", mtime, exp_mtime());

        mem_valid = 1'b1;
        mem_addr  = 32'h0200_0000;
        mem_wdata = 32'h0000_0001;
        mem_wstrb = 4'b0001;
        @(negedge clk);
        check("resp ready", 64'(mem_ready), 64'd1);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        #2 rst = 1'b1;
        #1 check("async ready", 64'(mem_ready), 64'd0);
        check("async rdata", 64'(mem_rdata), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        mt_base   = 64'd0;
        ecnt_base = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("presc mtime4 %0d", k + 1), mtime4, exp4_tbl[k]);
        end
        check("no commit msip", 64'(msip), 64'd0);
        check("mtime after rst", mtime, 64'd8);
        check("ready after rst", 64'(mem_ready), 64'd0);
        bus("rd cmp after rst", 32'h0200_4000, 32'd0, 4'd0, rd);
        check("cmp after rst", 64'(rd), 64'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
